// File: rtl/cubo_pkg.sv
// rtl/cubo_pkg.sv - shared state encoding, color codes and sizes for the cube-scan path
package cubo_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    CAPTURA        = 4'd1,
    ESPERA_CAPTURA = 4'd2,
    IDENTIFICA     = 4'd3,
    ESPERA_CORES   = 4'd4,
    VERIFICA       = 4'd5,
    GIRA           = 4'd6,
    ESPERA_GIRO    = 4'd7,
    FIM            = 4'd8,
    ERRO           = 4'd9
  } estado_t;

  typedef enum logic [2:0] {
    BRANCO   = 3'd0,
    AMARELO  = 3'd1,
    VERMELHO = 3'd2,
    LARANJA  = 3'd3,
    AZUL     = 3'd4,
    VERDE    = 3'd5
  } cor_t;

  localparam int N_FACES_PADRAO    = 6;
  localparam int N_ADESIVOS_PADRAO = 9;
  localparam int CUBO_ADDR_W       = 6;
  localparam int FACE_W            = 3;
  localparam int ADESIVO_W         = 4;
  localparam int COR_W             = 3;
  localparam logic [ADESIVO_W-1:0] ADESIVO_CENTRO = 4'd4;

  function automatic logic cor_valida(input logic [COR_W-1:0] cor);
    return cor <= VERDE;
  endfunction

endpackage

// File: rtl/sequenciador_faces_fd.sv
// rtl/sequenciador_faces_fd.sv - face/sticker counters, address adder, center check, write register
module sequenciador_faces_fd
  import cubo_pkg::*;
#(
  parameter int N_FACES    = N_FACES_PADRAO,
  parameter int N_ADESIVOS = N_ADESIVOS_PADRAO
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   limpa,
  input  logic                   limpa_adesivo,
  input  logic                   conta_face,
  input  logic                   aceita_cor,
  input  logic                   we_cor,
  input  logic [COR_W-1:0]       cor_final,
  output logic                   face_ok,
  output logic                   ultima_face,
  output logic                   we_cubo,
  output logic [CUBO_ADDR_W-1:0] cubo_addr,
  output logic [COR_W-1:0]       cubo_dado,
  output logic [FACE_W-1:0]      face_atual
);

  localparam logic [ADESIVO_W-1:0] N_ADES_L  = N_ADESIVOS[ADESIVO_W-1:0];
  localparam logic [FACE_W-1:0]    FACE_ULT  = FACE_W'(N_FACES - 1);

  logic [FACE_W-1:0]      face;
  logic [ADESIVO_W-1:0]   adesivo;
  logic [7:0]             mascara_centro;
  logic                   falha;
  logic [CUBO_ADDR_W-1:0] face_ext;
  logic [CUBO_ADDR_W-1:0] base_face;
  logic [CUBO_ADDR_W-1:0] addr_calc;
  logic                   escrita;

  // face*9 as (face<<3)+face keeps the adder at 6 bits
  assign face_ext  = {3'b000, face};
  assign base_face = (face_ext << 3) + face_ext;
  assign addr_calc = base_face + {2'b00, adesivo};
  assign escrita   = aceita_cor && we_cor;

  always_ff @(posedge clock) begin
    if (reset) begin
      face           <= '0;
      adesivo        <= '0;
      mascara_centro <= '0;
      falha          <= 1'b0;
      we_cubo        <= 1'b0;
      cubo_addr      <= '0;
      cubo_dado      <= '0;
    end else begin
      we_cubo <= 1'b0;
      if (limpa) begin
        face           <= '0;
        adesivo        <= '0;
        mascara_centro <= '0;
        falha          <= 1'b0;
      end else begin
        if (conta_face) face <= face + 3'd1;
        if (limpa_adesivo) begin
          adesivo <= '0;
        end else if (escrita) begin
          if (adesivo < N_ADES_L) begin
            we_cubo   <= 1'b1;
            cubo_addr <= addr_calc;
            cubo_dado <= cor_final;
            adesivo   <= adesivo + 4'd1;
            if (!cor_valida(cor_final)) falha <= 1'b1;
            if (adesivo == ADESIVO_CENTRO) begin
              if (mascara_centro[cor_final]) falha <= 1'b1;
              else mascara_centro[cor_final] <= 1'b1;
            end
          end else begin
            falha <= 1'b1;
          end
        end
      end
    end
  end

  assign face_ok     = (adesivo == N_ADES_L) && !falha;
  assign ultima_face = (face == FACE_ULT);
  assign face_atual  = face;

endmodule

// File: rtl/sequenciador_faces_uc.sv
// rtl/sequenciador_faces_uc.sv - face-scan FSM: sequencing, pulse decode, status flags
module sequenciador_faces_uc
  import cubo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       captura_feita,
  input  logic       cores_pronto,
  input  logic       giro_feito,
  input  logic       face_ok,
  input  logic       ultima_face,
  output logic       limpa,
  output logic       limpa_adesivo,
  output logic       aceita_cor,
  output logic       conta_face,
  output logic       inicia_captura,
  output logic       inicia_cores,
  output logic       gira_cubo,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  estado_t estado, prox_estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      pronto <= 1'b0;
      erro   <= 1'b0;
    end else begin
      estado <= prox_estado;
      // Status drops as soon as a restart is requested
      pronto <= (estado == FIM) && !iniciar;
      erro   <= (estado == ERRO) && !iniciar;
    end
  end

  always_comb begin
    prox_estado    = estado;
    limpa          = 1'b0;
    limpa_adesivo  = 1'b0;
    aceita_cor     = 1'b0;
    conta_face     = 1'b0;
    inicia_captura = 1'b0;
    inicia_cores   = 1'b0;
    gira_cubo      = 1'b0;
    case (estado)
      INICIAL, FIM, ERRO: begin
        if (iniciar) begin
          limpa       = 1'b1;
          prox_estado = CAPTURA;
        end
      end
      CAPTURA: begin
        inicia_captura = 1'b1;
        prox_estado    = ESPERA_CAPTURA;
      end
      ESPERA_CAPTURA: begin
        if (captura_feita) prox_estado = IDENTIFICA;
      end
      IDENTIFICA: begin
        inicia_cores  = 1'b1;
        limpa_adesivo = 1'b1;
        prox_estado   = ESPERA_CORES;
      end
      ESPERA_CORES: begin
        aceita_cor = 1'b1;
        if (cores_pronto) prox_estado = VERIFICA;
      end
      VERIFICA: begin
        if (!face_ok) begin
          prox_estado = ERRO;
        end else if (ultima_face) begin
          prox_estado = FIM;
        end else begin
          conta_face  = 1'b1;
          prox_estado = GIRA;
        end
      end
      GIRA: begin
        gira_cubo   = 1'b1;
        prox_estado = ESPERA_GIRO;
      end
      ESPERA_GIRO: begin
        if (giro_feito) prox_estado = CAPTURA;
      end
      default: prox_estado = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: rtl/sequenciador_faces.sv
// rtl/sequenciador_faces.sv - six-face scan controller top: FSM plus datapath
module sequenciador_faces
  import cubo_pkg::*;
#(
  parameter int N_FACES    = N_FACES_PADRAO,
  parameter int N_ADESIVOS = N_ADESIVOS_PADRAO
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  output logic                   inicia_captura,
  input  logic                   captura_feita,
  output logic                   inicia_cores,
  input  logic                   we_cor,
  input  logic [COR_W-1:0]       cor_final,
  input  logic                   cores_pronto,
  output logic                   gira_cubo,
  input  logic                   giro_feito,
  output logic                   we_cubo,
  output logic [CUBO_ADDR_W-1:0] cubo_addr,
  output logic [COR_W-1:0]       cubo_dado,
  output logic [FACE_W-1:0]      face_atual,
  output logic                   pronto,
  output logic                   erro,
  output logic [3:0]             db_estado
);

  logic limpa, limpa_adesivo, aceita_cor, conta_face, face_ok, ultima_face;

  sequenciador_faces_uc u_uc (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .captura_feita  (captura_feita),
    .cores_pronto   (cores_pronto),
    .giro_feito     (giro_feito),
    .face_ok        (face_ok),
    .ultima_face    (ultima_face),
    .limpa          (limpa),
    .limpa_adesivo  (limpa_adesivo),
    .aceita_cor     (aceita_cor),
    .conta_face     (conta_face),
    .inicia_captura (inicia_captura),
    .inicia_cores   (inicia_cores),
    .gira_cubo      (gira_cubo),
    .pronto         (pronto),
    .erro           (erro),
    .db_estado      (db_estado)
  );

  sequenciador_faces_fd #(
    .N_FACES    (N_FACES),
    .N_ADESIVOS (N_ADESIVOS)
  ) u_fd (
    .clock         (clock),
    .reset         (reset),
    .limpa         (limpa),
    .limpa_adesivo (limpa_adesivo),
    .conta_face    (conta_face),
    .aceita_cor    (aceita_cor),
    .we_cor        (we_cor),
    .cor_final     (cor_final),
    .face_ok       (face_ok),
    .ultima_face   (ultima_face),
    .we_cubo       (we_cubo),
    .cubo_addr     (cubo_addr),
    .cubo_dado     (cubo_dado),
    .face_atual    (face_atual)
  );

endmodule

// File: doc/sequenciador_faces.md
# sequenciador_faces

Top-level scan controller for the cube-reading path. Sequences six face acquisitions: camera capture, then a color-identification run, then a cube rotation. Collects the nine per-sticker colors streamed out by the color identifier and writes them into the 54-entry cube-state memory. Validates sticker count, color codes and center uniqueness, and hands a complete cube state to the solver.

## Interface

**Parameters**
- `N_FACES`, default 6: faces scanned per run.
- `N_ADESIVOS`, default 9: stickers per face.

**Ports**
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; returns block to INICIAL.
- `iniciar`  in  1  start pulse; honoured in INICIAL, FIM, ERRO.
- `inicia_captura`  out  1  one-cycle pulse to camera capture.
- `captura_feita`  in  1  camera frame stored in pixel memory.
- `inicia_cores`  out  1  one-cycle pulse to color identifier `iniciar`.
- `we_cor`  in  1  color identifier: `cor_final` valid this cycle.
- `cor_final`  in  3  sticker color code; 0..5 valid, 6..7 invalid.
- `cores_pronto`  in  1  color identifier finished current face.
- `gira_cubo`  out  1  one-cycle pulse requesting rotation to next face.
- `giro_feito`  in  1  rotation mechanism done.
- `we_cubo`  out  1  write strobe to cube-state memory.
- `cubo_addr`  out  6  write address = face*9 + sticker.
- `cubo_dado`  out  3  color written.
- `face_atual`  out  3  index of face being scanned.
- `pronto`  out  1  held high in FIM.
- `erro`  out  1  held high in ERRO.
- `db_estado`  out  4  current state encoding.

## Operation

**State machine** (encodings 0..9):
- INICIAL(0): on `iniciar`, clear face counter, sticker counter and center mask, then go to CAPTURA.
- CAPTURA(1): assert `inicia_captura` for one cycle, then go to ESPERA_CAPTURA.
- ESPERA_CAPTURA(2): wait for `captura_feita`, then go to IDENTIFICA.
- IDENTIFICA(3): assert `inicia_cores` for one cycle, clear sticker counter, then go to ESPERA_CORES.
- ESPERA_CORES(4): on each `we_cor`, register a write (see below). On `cores_pronto`, go to VERIFICA.
- VERIFICA(5):
  - Sticker count ≠ `N_ADESIVOS` or error flag set: go to ERRO.
  - Otherwise, on the last face: go to FIM.
  - Otherwise: increment face counter, go to GIRA.
- GIRA(6): assert `gira_cubo` for one cycle, then go to ESPERA_GIRO.
- ESPERA_GIRO(7): wait for `giro_feito`, then go to CAPTURA.
- FIM(8): `pronto`=1; on `iniciar`, go to INICIAL-clear path and then CAPTURA.
- ERRO(9): `erro`=1; on `iniciar`, same restart as FIM.

**Sticker write path**
- `we_cor` in ESPERA_CORES with sticker counter < 9:
  - Next cycle: `we_cubo`=1, `cubo_addr`=face*9+counter, `cubo_dado`=cor.
  - Counter increments.
- `we_cor` with counter already 9: no memory write; sets error flag.
- `cor_final` 6 or 7: still written; sets error flag.
- Sticker 4 (center): if bit `cor_final` of the 8-bit center mask is already set, set error flag. Otherwise set that bit.
- `we_cor` outside ESPERA_CORES: ignored.
- `we_cor` and `cores_pronto` in the same cycle: the sticker is counted first, then the transition is taken.

**Arithmetic**
- Address uses a 6-bit adder: face (3 bits) × 9 computed as (face<<3)+face. Maximum value 53.

**Reset values**
- All pulse outputs, `we_cubo`, `pronto`, `erro`: 0.
- `cubo_addr`, `cubo_dado`, `face_atual`: 0.
- `db_estado`: 0.
- Reset in any state, including mid-rotation, aborts immediately. No memory write occurs in the reset cycle.

## Timing

- `inicia_captura`, `inicia_cores`, `gira_cubo`: exactly one cycle, in the cycle the FSM occupies the pulse state.
- `we_cubo`: one-cycle latency after `we_cor`; back-to-back `we_cor` produces back-to-back writes.
- Minimum per face: 1 + capture + 1 + color run + 1 + 1 + rotation cycles.
- `face_atual` updates on exit from VERIFICA and is stable during capture and identification.
- `pronto`/`erro` are registered state decodes, high the cycle after entering FIM/ERRO, and stay high until `iniciar` or `reset`.
- Handshake inputs are level-sampled only in their wait state. Early assertions in other states are ignored.

## Structure

**Shared package `cubo_pkg`**
- State encoding constants.
- Color codes: BRANCO=0, AMARELO=1, VERMELHO=2, LARANJA=3, AZUL=4, VERDE=5.
- `N_FACES`/`N_ADESIVOS` defaults.
- `CUBO_ADDR_W`=6.

**Sub-modules**
- Split into `sequenciador_faces_uc` (FSM, pulse decode, `db_estado`) and `sequenciador_faces_fd` (face and sticker counters, address adder, center mask, error flag, write register), wired in the top.

## Test plan

- Full run, 6 faces: centers 0..5, all stickers = face index, 9 `we_cor` per face. Required: 54 writes at addresses 0..53 with correct data, 5 `gira_cubo` pulses, `pronto`=1, `erro`=0.
- Face 2 gets only 8 `we_cor` before `cores_pronto`. Required: ERRO (`db_estado`=9), `erro`=1, no `gira_cubo` after face 2.
- Face 3 center = 1, duplicating face 1. Required: ERRO after face 3 VERIFICA, `face_atual`=3.
- `cor_final`=7 on sticker 0 of face 0. Required: written at addr 0 with data 7, then ERRO at VERIFICA.
- `reset` asserted during ESPERA_GIRO of face 4. Required: next cycle INICIAL, all outputs 0. A subsequent `iniciar` restarts at face 0, addr 0.
- `we_cor` and `cores_pronto` in the same cycle on the 9th sticker. Required: 9th write issued at face*9+8, face passes, `gira_cubo` follows.
